// File: rtl/banco_registradores_ctx.sv
// Register bank with two read ports and one write port, a hard-wired zero register,
// a frame-pointer tap, optional write-to-read bypass, and a sequential context
// save/restore engine that copies between the main bank and a shadow bank.
module banco_registradores_ctx #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned FP_REG   = 29,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Reg1,
  input  logic [ADDR_W-1:0] Reg2,
  input  logic [ADDR_W-1:0] RegEscrita,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] EscreveDado,
  output logic [DATA_W-1:0] Dado1,
  output logic [DATA_W-1:0] Dado2,
  output logic [DATA_W-1:0] DadoNoRegDeEscrita,
  output logic [DATA_W-1:0] FP,
  input  logic [DATA_W-1:0] IntPC,
  input  logic              CtxSave,
  input  logic              CtxRestore,
  output logic              CtxBusy,
  output logic              CtxDone,
  output logic [DATA_W-1:0] EPC
);

  localparam int unsigned       NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] FP_IDX   = ADDR_W'(FP_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_RESTORE,
    S_DONE
  } ctx_state_e;

  ctx_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] main_q   [NREGS];
  logic [DATA_W-1:0] shadow_q [NREGS];

  logic wr_acc;
  logic byp1;
  logic byp2;

  // Write acceptance: the zero register is never written and the bank is frozen while the engine runs.
  always_comb begin
    wr_acc = RegWrite && (RegEscrita != ZERO_IDX) && !busy_q;
    byp1   = (BYPASS != 0) && wr_acc && (RegEscrita == Reg1);
    byp2   = (BYPASS != 0) && wr_acc && (RegEscrita == Reg2);
  end

  // Context engine: next state, copy counter, EPC capture; Busy/Done are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    case (state_q)
      S_IDLE: begin
        if (CtxSave) begin
          state_d = S_SAVE;
          epc_d   = IntPC;
          cnt_d   = '0;
        end else if (CtxRestore) begin
          state_d = S_RESTORE;
          cnt_d   = '0;
        end
      end
      S_SAVE, S_RESTORE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SAVE) || (state_d == S_RESTORE);
    done_d = (state_d == S_DONE);
  end

  // Context engine state registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Main and shadow banks: pipeline writes when idle, one-entry-per-cycle copies while saving/restoring.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        main_q[RegEscrita] <= EscreveDado;
      end
      if (state_q == S_SAVE) begin
        shadow_q[cnt_q] <= main_q[cnt_q];
      end
      if ((state_q == S_RESTORE) && (cnt_q != ZERO_IDX)) begin
        main_q[cnt_q] <= shadow_q[cnt_q];
      end
    end
  end

  // Read ports: zero register forced to 0, optional same-cycle forwarding on the two decode ports.
  always_comb begin
    Dado1              = (Reg1 == ZERO_IDX) ? '0 : (byp1 ? EscreveDado : main_q[Reg1]);
    Dado2              = (Reg2 == ZERO_IDX) ? '0 : (byp2 ? EscreveDado : main_q[Reg2]);
    DadoNoRegDeEscrita = (RegEscrita == ZERO_IDX) ? '0 : main_q[RegEscrita];
    FP                 = (FP_IDX == ZERO_IDX) ? '0 : main_q[FP_IDX];
    CtxBusy            = busy_q;
    CtxDone            = done_q;
    EPC                = epc_q;
  end

endmodule

// File: tb/tb_banco_registradores_ctx.sv
// Self-checking bench: two instances (bypass on/off) driven by the same stimulus,
// compared against an array-based reference model of the register bank.
module tb_banco_registradores_ctx;

  localparam int NREGS = 32;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [4:0]  Reg1, Reg2, RegEscrita;
  logic        RegWrite;
  logic [31:0] EscreveDado, IntPC;
  logic        CtxSave, CtxRestore;

  logic [31:0] Dado1, Dado2, DadoNoRegDeEscrita, FP, EPC;
  logic        CtxBusy, CtxDone;
  logic [31:0] nb_Dado1, nb_Dado2, nb_DadoNoRegDeEscrita, nb_FP, nb_EPC;
  logic        nb_CtxBusy, nb_CtxDone;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [31:0] m_main   [NREGS];
  logic [31:0] m_shadow [NREGS];
  logic [31:0] m_epc;
  bit          m_busy, m_done, m_is_save;
  int          m_cnt;

  banco_registradores_ctx #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(31), .FP_REG(29), .BYPASS(1)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Reg1(Reg1), .Reg2(Reg2), .RegEscrita(RegEscrita),
    .RegWrite(RegWrite), .EscreveDado(EscreveDado), .Dado1(Dado1), .Dado2(Dado2),
    .DadoNoRegDeEscrita(DadoNoRegDeEscrita), .FP(FP), .IntPC(IntPC), .CtxSave(CtxSave),
    .CtxRestore(CtxRestore), .CtxBusy(CtxBusy), .CtxDone(CtxDone), .EPC(EPC)
  );

  banco_registradores_ctx #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(31), .FP_REG(29), .BYPASS(0)) u_dut_nb (
    .Clock(Clock), .Reset_n(Reset_n), .Reg1(Reg1), .Reg2(Reg2), .RegEscrita(RegEscrita),
    .RegWrite(RegWrite), .EscreveDado(EscreveDado), .Dado1(nb_Dado1), .Dado2(nb_Dado2),
    .DadoNoRegDeEscrita(nb_DadoNoRegDeEscrita), .FP(nb_FP), .IntPC(IntPC), .CtxSave(CtxSave),
    .CtxRestore(CtxRestore), .CtxBusy(nb_CtxBusy), .CtxDone(nb_CtxDone), .EPC(nb_EPC)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_main[i]   = '0;
      m_shadow[i] = '0;
    end
    m_epc = '0; m_busy = 0; m_done = 0; m_is_save = 0; m_cnt = 0;
  endfunction

  // expected read value for an index given the currently driven inputs
  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd31) return '0;
    if (byp && RegWrite && !m_busy && RegEscrita == idx) return EscreveDado;
    return m_main[idx];
  endfunction

  // advance the model by one rising edge using the currently driven inputs
  function automatic void model_step();
    if (!m_busy && RegWrite && RegEscrita != 5'd31) m_main[RegEscrita] = EscreveDado;
    if (m_busy) begin
      if (m_is_save) m_shadow[m_cnt] = m_main[m_cnt];
      else if (m_cnt != 31) m_main[m_cnt] = m_shadow[m_cnt];
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (CtxSave) begin
      m_epc = IntPC; m_busy = 1; m_is_save = 1; m_cnt = 0;
    end else if (CtxRestore) begin
      m_busy = 1; m_is_save = 0; m_cnt = 0;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegEscrita = a; EscreveDado = d; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; RegWrite = 0; CtxSave = 0; CtxRestore = 0;
    Reg1 = 0; Reg2 = 0; RegEscrita = 0; EscreveDado = 0; IntPC = 0;
    model_reset();
    #2;
    n_checks++;
    if (CtxBusy !== 1'b0 || CtxDone !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", CtxBusy, CtxDone);
    end
    n_checks++;
    if (EPC !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", EPC); end
    n_checks++;
    if (FP !== 32'h0) begin n_fail++; $display("FAIL reset_fp: got %h expected 0", FP); end
    for (int i = 0; i < NREGS; i++) begin
      Reg1 = 5'(i); #1;
      n_checks++;
      if (Dado1 !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, Dado1); end
    end
    @(negedge Clock); Reset_n = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic_rw();
    wr(5'd1, 32'd102);
    wr(5'd2, 32'd54);
    Reg1 = 5'd1; Reg2 = 5'd2; #1;
    n_checks++;
    if (Dado1 !== 32'd102) begin n_fail++; $display("FAIL rw_r1: got %0d expected 102", Dado1); end
    n_checks++;
    if (Dado2 !== 32'd54) begin n_fail++; $display("FAIL rw_r2: got %0d expected 54", Dado2); end
    wr(5'd31, 32'hFFFF_FFFF);
    Reg1 = 5'd31; RegEscrita = 5'd31; #1;
    n_checks++;
    if (Dado1 !== 32'h0) begin n_fail++; $display("FAIL rw_zero: got %h expected 0", Dado1); end
    n_checks++;
    if (DadoNoRegDeEscrita !== 32'h0) begin
      n_fail++; $display("FAIL rw_zero_wrport: got %h expected 0", DadoNoRegDeEscrita);
    end
  endtask

  task automatic test_bypass();
    Reg1 = 5'd3; RegEscrita = 5'd3; EscreveDado = 32'd4; RegWrite = 1'b1; #1;
    n_checks++;
    if (Dado1 !== 32'd4) begin n_fail++; $display("FAIL byp_on: got %0d expected 4", Dado1); end
    n_checks++;
    if (DadoNoRegDeEscrita !== 32'd0) begin
      n_fail++; $display("FAIL byp_wrport_old: got %0d expected 0", DadoNoRegDeEscrita);
    end
    n_checks++;
    if (nb_Dado1 !== 32'd0) begin n_fail++; $display("FAIL byp_off_pre: got %0d expected 0", nb_Dado1); end
    tick();
    RegWrite = 1'b0; #1;
    n_checks++;
    if (nb_Dado1 !== 32'd4 || Dado1 !== 32'd4) begin
      n_fail++; $display("FAIL byp_post: got %0d/%0d expected 4/4", Dado1, nb_Dado1);
    end
    Reg2 = 5'd31; RegEscrita = 5'd31; EscreveDado = 32'hABCD; RegWrite = 1'b1; #1;
    n_checks++;
    if (Dado2 !== 32'h0) begin n_fail++; $display("FAIL byp_zero: got %h expected 0", Dado2); end
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 300; n++) begin
      Reg1 = 5'($urandom); Reg2 = 5'($urandom);
      RegEscrita = ($urandom % 4 == 0) ? Reg1 : 5'($urandom);
      RegWrite = 1'($urandom); EscreveDado = $urandom;
      #1;
      n_checks++;
      if (Dado1 !== exp_rd(Reg1, 1)) begin
        n_fail++; $display("FAIL rnd_d1 r%0d: got %h expected %h", Reg1, Dado1, exp_rd(Reg1, 1));
      end
      n_checks++;
      if (Dado2 !== exp_rd(Reg2, 1)) begin
        n_fail++; $display("FAIL rnd_d2 r%0d: got %h expected %h", Reg2, Dado2, exp_rd(Reg2, 1));
      end
      n_checks++;
      if (nb_Dado1 !== exp_rd(Reg1, 0)) begin
        n_fail++; $display("FAIL rnd_nb_d1 r%0d: got %h expected %h", Reg1, nb_Dado1, exp_rd(Reg1, 0));
      end
      n_checks++;
      if (DadoNoRegDeEscrita !== exp_rd(RegEscrita, 0)) begin
        n_fail++; $display("FAIL rnd_wrport r%0d: got %h expected %h", RegEscrita, DadoNoRegDeEscrita,
                           exp_rd(RegEscrita, 0));
      end
      n_checks++;
      if (FP !== m_main[29]) begin n_fail++; $display("FAIL rnd_fp: got %h expected %h", FP, m_main[29]); end
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_save();
    int busy_cycles = 0;
    int done_cycles = 0;
    wr(5'd1, 32'd102);
    wr(5'd29, 32'h100);
    IntPC = 32'h40; CtxSave = 1'b1;
    tick();
    CtxSave = 1'b0;
    for (int c = 0; c < 40; c++) begin
      RegWrite = m_busy; RegEscrita = 5'd1; EscreveDado = $urandom; Reg1 = 5'($urandom);
      #1;
      if (CtxBusy) busy_cycles++;
      if (CtxDone) done_cycles++;
      n_checks++;
      if (CtxBusy !== m_busy || CtxDone !== m_done) begin
        n_fail++; $display("FAIL save_flags c%0d: busy=%b done=%b expected %b %b", c, CtxBusy, CtxDone, m_busy, m_done);
      end
      n_checks++;
      if (Dado1 !== exp_rd(Reg1, 1)) begin
        n_fail++; $display("FAIL save_read r%0d: got %h expected %h", Reg1, Dado1, exp_rd(Reg1, 1));
      end
      tick();
    end
    RegWrite = 1'b0;
    n_checks++;
    if (busy_cycles != 32) begin n_fail++; $display("FAIL save_busy_len: got %0d expected 32", busy_cycles); end
    n_checks++;
    if (done_cycles != 1) begin n_fail++; $display("FAIL save_done_len: got %0d expected 1", done_cycles); end
    n_checks++;
    if (EPC !== 32'h40) begin n_fail++; $display("FAIL save_epc: got %h expected 40", EPC); end
    Reg1 = 5'd1; #1;
    n_checks++;
    if (Dado1 !== 32'd102) begin n_fail++; $display("FAIL save_r1_kept: got %0d expected 102", Dado1); end
  endtask

  task automatic test_restore();
    bit seen_done = 0;
    wr(5'd1, 32'd7);
    wr(5'd29, 32'h0);
    CtxRestore = 1'b1;
    tick();
    CtxRestore = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      RegWrite = m_busy; RegEscrita = 5'($urandom); EscreveDado = $urandom; Reg1 = 5'($urandom);
      #1;
      if (CtxDone) seen_done = 1;
      n_checks++;
      if (CtxBusy !== m_busy || CtxDone !== m_done) begin
        n_fail++; $display("FAIL rest_flags c%0d: busy=%b done=%b expected %b %b", c, CtxBusy, CtxDone, m_busy, m_done);
      end
      n_checks++;
      if (Dado1 !== exp_rd(Reg1, 1)) begin
        n_fail++; $display("FAIL rest_read r%0d: got %h expected %h", Reg1, Dado1, exp_rd(Reg1, 1));
      end
      tick();
    end
    RegWrite = 1'b0;
    n_checks++;
    if (!seen_done) begin n_fail++; $display("FAIL rest_timeout: done=0 expected 1 within 40 cycles"); end
    Reg1 = 5'd1; Reg2 = 5'd31; #1;
    n_checks++;
    if (Dado1 !== 32'd102) begin n_fail++; $display("FAIL rest_r1: got %0d expected 102", Dado1); end
    n_checks++;
    if (FP !== 32'h100) begin n_fail++; $display("FAIL rest_fp: got %h expected 100", FP); end
    n_checks++;
    if (Dado2 !== 32'h0) begin n_fail++; $display("FAIL rest_zero: got %h expected 0", Dado2); end
    n_checks++;
    if (EPC !== 32'h40) begin n_fail++; $display("FAIL rest_epc: got %h expected 40", EPC); end
  endtask

  task automatic test_priority_and_ignored();
    int dones = 0;
    IntPC = 32'h1234; CtxSave = 1'b1; CtxRestore = 1'b1;
    tick();
    CtxSave = 1'b0; CtxRestore = 1'b0;
    n_checks++;
    if (EPC !== 32'h1234 || CtxBusy !== 1'b1) begin
      n_fail++; $display("FAIL prio_save: epc=%h busy=%b expected 1234 1", EPC, CtxBusy);
    end
    for (int c = 0; c < 80; c++) begin
      CtxSave    = (c == 5) || m_done;
      CtxRestore = (c == 20);
      IntPC      = 32'hBAD0 + 32'(c);
      Reg1       = 5'($urandom);
      #1;
      if (CtxDone) dones++;
      n_checks++;
      if (CtxBusy !== m_busy || CtxDone !== m_done) begin
        n_fail++; $display("FAIL prio_flags c%0d: busy=%b done=%b expected %b %b", c, CtxBusy, CtxDone, m_busy, m_done);
      end
      n_checks++;
      if (Dado1 !== exp_rd(Reg1, 1)) begin
        n_fail++; $display("FAIL prio_read r%0d: got %h expected %h", Reg1, Dado1, exp_rd(Reg1, 1));
      end
      if (c == 40) begin CtxSave = 0; CtxRestore = 0; end
      tick();
      if (c >= 40) begin CtxSave = 0; CtxRestore = 0; end
    end
    CtxSave = 0; CtxRestore = 0;
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL prio_single_done: got %0d expected 1", dones); end
    n_checks++;
    if (EPC !== 32'h1234) begin n_fail++; $display("FAIL prio_epc_kept: got %h expected 1234", EPC); end
  endtask

  task automatic test_reset_mid_save();
    int busy_cycles = 0;
    bit seen_done = 0;
    wr(5'd5, 32'h5555);
    IntPC = 32'h99; CtxSave = 1'b1;
    tick();
    CtxSave = 1'b0;
    repeat (10) tick();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (CtxBusy !== 1'b0 || CtxDone !== 1'b0) begin
      n_fail++; $display("FAIL arst_flags: busy=%b done=%b expected 0 0", CtxBusy, CtxDone);
    end
    n_checks++;
    if (EPC !== 32'h0) begin n_fail++; $display("FAIL arst_epc: got %h expected 0", EPC); end
    for (int i = 0; i < NREGS; i++) begin
      Reg1 = 5'(i); #1;
      n_checks++;
      if (Dado1 !== 32'h0) begin n_fail++; $display("FAIL arst_reg%0d: got %h expected 0", i, Dado1); end
    end
    @(negedge Clock); Reset_n = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if (CtxBusy !== 1'b0 || CtxDone !== 1'b0) begin
      n_fail++; $display("FAIL arst_idle: busy=%b done=%b expected 0 0", CtxBusy, CtxDone);
    end
    IntPC = 32'h77; CtxSave = 1'b1;
    tick();
    CtxSave = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      #1;
      if (CtxBusy) busy_cycles++;
      if (CtxDone) seen_done = 1;
      tick();
    end
    n_checks++;
    if (busy_cycles != 32 || !seen_done) begin
      n_fail++; $display("FAIL arst_resave: busy=%0d done_seen=%b expected 32 1", busy_cycles, seen_done);
    end
    n_checks++;
    if (EPC !== 32'h77) begin n_fail++; $display("FAIL arst_resave_epc: got %h expected 77", EPC); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_random_rw();
    test_save();
    test_restore();
    test_priority_and_ignored();
    test_random_rw();
    test_reset_mid_save();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
